// File: rtl/pixel_framebuf.sv
// pixel_framebuf: 160x120x3 framebuffer with a plot port and a streaming raster scan-out.
// Defining FB_CLEAR_EN adds a full-frame clear engine driven by the clear input.
module pixel_framebuf (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       plot,
   input  logic [7:0] x,
   input  logic [6:0] y,
   input  logic [2:0] colour,
   input  logic       clear,
   output logic       busy,
   output logic       dropped,
   input  logic       out_ready,
   output logic       out_valid,
   output logic [7:0] out_x,
   output logic [6:0] out_y,
   output logic [2:0] out_colour,
   output logic       out_sof,
   output logic       out_eol
);
   localparam int NPIX = 19200;

   function automatic logic [14:0] pix_addr(input logic [7:0] px, input logic [6:0] py);
      return 15'(py) * 15'd160 + 15'(px);
   endfunction

   logic [2:0]  mem_q [NPIX];
   logic        in_range, we, dropped_q;
   logic [14:0] waddr;
   logic [2:0]  wdata;

   assign in_range = (x < 8'd160) && (y < 7'd120);

`ifdef FB_CLEAR_EN
   typedef enum logic {W_IDLE, W_CLEAR} wstate_e;
   wstate_e     wstate_q;
   logic [14:0] clr_addr_q;
   logic        busy_q, accept;
   // a plot coinciding with a clear request loses to the clear
   assign accept = plot && in_range && (wstate_q == W_IDLE) && !clear;
   assign we     = accept || (wstate_q == W_CLEAR);
   assign waddr  = (wstate_q == W_CLEAR) ? clr_addr_q : pix_addr(x, y);
   assign wdata  = (wstate_q == W_CLEAR) ? 3'd0 : colour;
   assign busy   = busy_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wstate_q   <= W_IDLE;
         clr_addr_q <= '0;
         busy_q     <= 1'b0;
         dropped_q  <= 1'b0;
      end else begin
         dropped_q <= plot && !accept;
         case (wstate_q)
            W_IDLE: if (clear) begin
               wstate_q   <= W_CLEAR;
               busy_q     <= 1'b1;
               clr_addr_q <= '0;
            end
            W_CLEAR: begin
               clr_addr_q <= clr_addr_q + 15'd1;
               if (clr_addr_q == 15'(NPIX - 1)) begin
                  wstate_q <= W_IDLE;
                  busy_q   <= 1'b0;
               end
            end
            default: wstate_q <= W_IDLE;
         endcase
      end
   end
`else
   logic unused_clear;
   assign unused_clear = clear;
   assign we    = plot && in_range;
   assign waddr = pix_addr(x, y);
   assign wdata = colour;
   assign busy  = 1'b0;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) dropped_q <= 1'b0;
      else dropped_q <= plot && !in_range;
`endif

   assign dropped = dropped_q;

   typedef enum logic {R_FILL, R_VALID} rstate_e;
   rstate_e     rstate_q;
   logic [7:0]  rx_q, rx_d, ax_q, out_x_q;
   logic [6:0]  ry_q, ry_d, ay_q, out_y_q;
   logic [2:0]  rdata_q, out_colour_q;
   logic [14:0] raddr;
   logic        advance, rd_en, out_valid_q, out_sof_q, out_eol_q;

   // stage A (ax/ay/rdata) holds the pixel read last; output stage takes it on advance
   assign advance = (rstate_q == R_VALID) && (!out_valid_q || out_ready);
   assign rd_en   = (rstate_q == R_FILL) || advance;
   assign raddr   = pix_addr(rx_q, ry_q);
   assign rx_d    = (rx_q == 8'd159) ? 8'd0 : rx_q + 8'd1;
   assign ry_d    = (rx_q != 8'd159) ? ry_q : (ry_q == 7'd119) ? 7'd0 : ry_q + 7'd1;

   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
      if (rd_en) rdata_q <= mem_q[raddr];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rstate_q     <= R_FILL;
         rx_q         <= '0;
         ry_q         <= '0;
         ax_q         <= '0;
         ay_q         <= '0;
         out_valid_q  <= 1'b0;
         out_x_q      <= '0;
         out_y_q      <= '0;
         out_colour_q <= '0;
         out_sof_q    <= 1'b0;
         out_eol_q    <= 1'b0;
      end else if (rd_en) begin
         rstate_q <= R_VALID;
         ax_q     <= rx_q;
         ay_q     <= ry_q;
         rx_q     <= rx_d;
         ry_q     <= ry_d;
         if (advance) begin
            out_valid_q  <= 1'b1;
            out_x_q      <= ax_q;
            out_y_q      <= ay_q;
            out_colour_q <= rdata_q;
            out_sof_q    <= (ax_q == 8'd0) && (ay_q == 7'd0);
            out_eol_q    <= ax_q == 8'd159;
         end
      end
   end

   assign out_valid  = out_valid_q;
   assign out_x      = out_x_q;
   assign out_y      = out_y_q;
   assign out_colour = out_colour_q;
   assign out_sof    = out_sof_q;
   assign out_eol    = out_eol_q;
endmodule

// File: tb/tb_pixel_framebuf.sv
// tb_pixel_framebuf: directed checks of plot, drop, raster scan-out, stall and (with FB_CLEAR_EN) clear.
module tb_pixel_framebuf;
   logic       clk = 1'b0;
   logic       rst_n, plot, clear, out_ready;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour;
   logic       busy, dropped, out_valid, out_sof, out_eol;
   logic [7:0] out_x;
   logic [6:0] out_y;
   logic [2:0] out_colour;
   int         vectors = 0, errors = 0;

   always #5 clk = ~clk;

   pixel_framebuf dut (
      .clk(clk), .rst_n(rst_n), .plot(plot), .x(x), .y(y), .colour(colour),
      .clear(clear), .busy(busy), .dropped(dropped), .out_ready(out_ready),
      .out_valid(out_valid), .out_x(out_x), .out_y(out_y), .out_colour(out_colour),
      .out_sof(out_sof), .out_eol(out_eol)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(negedge clk);
   endtask

   task automatic do_plot(input int px, input int py, input int pc);
      x = 8'(px);
      y = 7'(py);
      colour = 3'(pc);
      plot = 1'b1;
      step();
      plot = 1'b0;
   endtask

   task automatic wait_pix(input int px, input int py);
      int n = 0;
      while (!(out_valid && out_x == 8'(px) && out_y == 7'(py)) && n < 20000) begin
         step();
         n++;
      end
      check("wait_pix", 32'(n < 20000), 1);
   endtask

   task automatic pulse_reset;
      rst_n = 1'b0;
      #1;
      check("arst_valid", out_valid, 0);
      check("arst_x", out_x, 0);
      check("arst_sof", out_sof, 0);
      check("arst_busy", busy, 0);
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      int eols, bad_eol, sofs, n, ex, ey, got, held;
      logic stalled;
      rst_n = 1'b0; plot = 1'b0; clear = 1'b0; out_ready = 1'b1;
      x = '0; y = '0; colour = '0;
      repeat (3) step();
      check("rst_valid", out_valid, 0);
      check("rst_sof", out_sof, 0);
      check("rst_eol", out_eol, 0);
      check("rst_busy", busy, 0);
      check("rst_dropped", dropped, 0);
      check("rst_x", out_x, 0);
      check("rst_y", out_y, 0);
      check("rst_colour", out_colour, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("edge1_valid", out_valid, 0);
      @(posedge clk); #1;
      check("edge2_valid", out_valid, 1);
      check("edge2_x", out_x, 0);
      check("edge2_y", out_y, 0);
      check("edge2_sof", out_sof, 1);
      check("edge2_eol", out_eol, 0);
      step();
      eols = 0; bad_eol = 0; sofs = 0;
      for (int i = 1; i <= 19200; i++) begin
         step();
         if (out_eol) eols++;
         if (out_eol && out_x != 8'd159) bad_eol++;
         if (out_sof) sofs++;
      end
      check("frame_eols", eols, 120);
      check("frame_bad_eol", bad_eol, 0);
      check("frame_sofs", sofs, 1);
      check("wrap_sof", out_sof, 1);
      check("wrap_x", out_x, 0);
      check("wrap_y", out_y, 0);
      // plots and drops; (160,0) would alias address 160 = (0,1)
      do_plot(0, 1, 4);
      check("plot_0_1_drop", dropped, 0);
      do_plot(5, 3, 6);
      check("plot_5_3_drop", dropped, 0);
      do_plot(160, 0, 1);
      check("drop_x160", dropped, 1);
      step();
      check("drop_pulse_end", dropped, 0);
      do_plot(0, 120, 1);
      check("drop_y120", dropped, 1);
`ifndef FB_CLEAR_EN
      clear = 1'b1;
      do_plot(1, 2, 3);
      clear = 1'b0;
      check("noclr_drop", dropped, 0);
      check("noclr_busy", busy, 0);
`endif
      wait_pix(0, 1);
      check("pix_0_1", out_colour, 4);
`ifndef FB_CLEAR_EN
      wait_pix(1, 2);
      check("pix_1_2", out_colour, 3);
`endif
      wait_pix(5, 3);
      check("pix_5_3", out_colour, 6);
      // read-first: plot (10,10) on the edge that reads it
      do_plot(10, 10, 2);
      wait_pix(8, 10);
      do_plot(10, 10, 7);
      wait_pix(10, 10);
      check("rdfirst_old", out_colour, 2);
      pulse_reset();
      wait_pix(0, 0);
      check("rerst_sof", out_sof, 1);
      wait_pix(5, 3);
      check("keep_5_3", out_colour, 6);
      wait_pix(10, 10);
      check("rdfirst_new", out_colour, 7);
`ifdef FB_CLEAR_EN
      for (int r = 0; r < 120; r++)
         for (int c = 0; c < 160; c++) begin
            x = 8'(c); y = 7'(r); colour = 3'd5; plot = 1'b1;
            step();
         end
      plot = 1'b0;
      step();
      check("fill_drop", dropped, 0);
      clear = 1'b1;
      step();
      clear = 1'b0;
      check("abort_busy", busy, 1);
      repeat (100) step();
      pulse_reset();
      wait_pix(0, 0);
      check("abort_0", out_colour, 0);
      wait_pix(99, 0);
      check("abort_99", out_colour, 0);
      wait_pix(100, 0);
      check("abort_100", out_colour, 5);
      wait_pix(0, 1);
      check("abort_160", out_colour, 5);
      clear = 1'b1;
      do_plot(1, 1, 3);
      clear = 1'b0;
      check("clr_plot_drop", dropped, 1);
      check("clr_busy", busy, 1);
      n = 0;
      for (int i = 0; i < 20000 && busy; i++) begin
         n++;
         if (n == 50) begin
            plot = 1'b1; x = 8'd2; y = 7'd2; colour = 3'd3; clear = 1'b1;
         end
         step();
         if (n == 50) begin
            check("busy_plot_drop", dropped, 1);
            plot = 1'b0;
            clear = 1'b0;
         end
      end
      check("busy_len", n, 19200);
      pulse_reset();
`else
      pulse_reset();
`endif
      // stalled frame from (0,0) with random ready
      wait_pix(0, 0);
      ex = 0; ey = 0; got = 0; held = 0; stalled = 1'b0;
      for (int c = 0; c < 60000 && got < 19200; c++) begin
         check("st_valid", out_valid, 1);
         check("st_x", out_x, ex);
         check("st_y", out_y, ey);
         check("st_eol", out_eol, 32'(ex == 159));
         check("st_sof", out_sof, 32'(ex == 0 && ey == 0));
         if (stalled) check("st_hold_col", out_colour, held);
`ifdef FB_CLEAR_EN
         check("st_cleared", out_colour, 0);
`endif
         if (c == 101) begin
            check("st_plot_drop", dropped, 0);
            plot = 1'b0;
         end
         out_ready = ($urandom_range(0, 7) != 0);
         if (c == 100) begin
            out_ready = 1'b0;
            x = 8'd20; y = 7'd20; colour = 3'd0; plot = 1'b1;
         end
         stalled = !out_ready;
         held = int'(out_colour);
         step();
         if (!stalled) begin
            got++;
            ey = (ex == 159) ? ((ey == 119) ? 0 : ey + 1) : ey;
            ex = (ex == 159) ? 0 : ex + 1;
         end
      end
      out_ready = 1'b1;
      check("st_count", got, 19200);
      check("st_wrap_sof", out_sof, 1);
      check("st_wrap_x", out_x, 0);
      check("st_wrap_y", out_y, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
